// File: rtl/rit_pkg.sv
// rit_pkg: shared types and constants for rand_interval_timer.
// FSM states, mode bit positions and LFSR tap selection.
package rit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int MODE_PERIODIC_BIT = 0;
    localparam int MODE_RANDOM_BIT   = 1;

    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    // Maximal-length Fibonacci taps for the supported LFSR widths.
    function automatic logic [31:0] lfsr_taps(input int w);
        logic [31:0] t;
        case (w)
            8:       t = TAPS_8;
            32:      t = TAPS_32;
            default: t = TAPS_16;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rit_lfsr.sv
// rit_lfsr: Fibonacci LFSR with seed load and zero-lock guard.
// A load always beats a step in the same cycle.
module rit_lfsr
    import rit_pkg::*;
#(
    parameter int LFSR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_fb;
    logic [LFSR_W-1:0] w_seed;

    assign w_fb   = ^(r_lfsr & TAPS);
    assign w_seed = (seed == '0) ? LFSR_W'(1) : seed;

    // Shift register: reset to 1, seed load, or one Fibonacci step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_W'(1);
        end else if (load) begin
            r_lfsr <= w_seed;
        end else if (step) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
        end
    end

    assign value = r_lfsr;

endmodule

// File: rtl/rand_interval_timer.sv
// rand_interval_timer: prescaled one-shot/periodic timer with LFSR-randomised interval.
// Optional reaction-time capture port set enabled by defining RIT_CAPTURE_EN.
module rand_interval_timer
    import rit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int LFSR_W     = 16,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      base,
    input  logic [WIDTH-1:0]      rand_mask,
    input  logic [LFSR_W-1:0]     seed,
    input  logic                  seed_load,
`ifdef RIT_CAPTURE_EN
    input  logic                  capture,
    output logic [WIDTH-1:0]      capture_val,
    output logic                  capture_valid,
`endif
    output logic                  busy,
    output logic                  expire,
    output logic [WIDTH-1:0]      count,
    output logic [WIDTH-1:0]      interval
);

    state_t                r_state;
    state_t                w_next;
    logic [PRESCALE_W-1:0] r_presc;
    logic [WIDTH-1:0]      r_count;
    logic [WIDTH-1:0]      r_interval;
    logic                  r_expire;
    logic                  r_periodic;

    logic [LFSR_W-1:0]     w_lfsr;
    logic [WIDTH-1:0]      w_lfsr_ext;
    logic [WIDTH-1:0]      w_rand;
    logic [WIDTH:0]        w_sum;
    logic [WIDTH-1:0]      w_load_val;
    logic [WIDTH-1:0]      w_count_inc;
    logic                  w_tick;
    logic                  w_done;
    logic                  w_do_load;
    logic                  w_run;
    logic                  w_step;
    logic                  w_cap;

    rit_lfsr #(
        .LFSR_W(LFSR_W)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (w_step),
        .load (seed_load),
        .seed (seed),
        .value(w_lfsr)
    );

    // Zero-extend (or truncate) the LFSR value to the interval width.
    always_comb begin
        w_lfsr_ext = '0;
        for (int i = 0; i < WIDTH && i < LFSR_W; i++) begin
            w_lfsr_ext[i] = w_lfsr[i];
        end
    end

    assign w_rand = mode[MODE_RANDOM_BIT] ? (w_lfsr_ext & rand_mask) : '0;
    assign w_sum  = {1'b0, base} + {1'b0, w_rand};

    // Saturate the interval sum and never allow a zero-length interval.
    always_comb begin
        w_load_val = w_sum[WIDTH-1:0];
        if (w_sum[WIDTH]) begin
            w_load_val = '1;
        end else if (w_sum[WIDTH-1:0] == '0) begin
            w_load_val = WIDTH'(1);
        end
    end

`ifdef RIT_CAPTURE_EN
    assign w_cap = capture && (r_state == RUN) && !stop;
`else
    assign w_cap = 1'b0;
`endif

    assign w_tick      = (r_state == RUN) && (r_presc == prescale);
    assign w_count_inc = r_count + WIDTH'(1);
    assign w_done      = w_tick && (w_count_inc == r_interval);
    assign w_do_load   = (r_state == LOAD) && !stop;
    assign w_run       = (r_state == RUN) && !stop && !w_cap;
    assign w_step      = w_do_load && mode[MODE_RANDOM_BIT];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: stop overrides everything, capture overrides expiry.
    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_next = LOAD;
                    end
                end
                LOAD: w_next = RUN;
                RUN: begin
                    if (w_cap) begin
                        w_next = IDLE;
                    end else if (w_done) begin
                        w_next = r_periodic ? LOAD : IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Interval latch, prescaler, tick counter and expire pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= '0;
            r_count    <= '0;
            r_interval <= '0;
            r_expire   <= 1'b0;
            r_periodic <= 1'b0;
        end else begin
            r_expire <= 1'b0;
            if (w_do_load) begin
                r_interval <= w_load_val;
                r_count    <= '0;
                r_presc    <= '0;
                r_periodic <= mode[MODE_PERIODIC_BIT];
            end else if (w_run) begin
                if (w_tick) begin
                    r_presc  <= '0;
                    r_count  <= w_count_inc;
                    r_expire <= w_done;
                end else begin
                    r_presc <= r_presc + PRESCALE_W'(1);
                end
            end
        end
    end

`ifdef RIT_CAPTURE_EN
    logic [WIDTH-1:0] r_cap_val;
    logic             r_cap_valid;

    // Capture the elapsed count; valid clears when the next run loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_val   <= '0;
            r_cap_valid <= 1'b0;
        end else if (w_do_load) begin
            r_cap_valid <= 1'b0;
        end else if (w_cap) begin
            r_cap_val   <= r_count;
            r_cap_valid <= 1'b1;
        end
    end

    assign capture_val   = r_cap_val;
    assign capture_valid = r_cap_valid;
`endif

    assign busy     = (r_state != IDLE);
    assign expire   = r_expire;
    assign count    = r_count;
    assign interval = r_interval;

endmodule

// File: tb/tb_rand_interval_timer.sv
// tb_rand_interval_timer: directed vector table plus hand sequences.
// Build with RIT_CAPTURE_EN defined to also exercise the capture port.
module tb_rand_interval_timer;

    localparam int W  = 8;
    localparam int LW = 16;
    localparam int PW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic [1:0]    mode;
    logic [PW-1:0] prescale;
    logic [W-1:0]  base;
    logic [W-1:0]  rand_mask;
    logic [LW-1:0] seed;
    logic          seed_load;
    logic          busy;
    logic          expire;
    logic [W-1:0]  count;
    logic [W-1:0]  interval;
`ifdef RIT_CAPTURE_EN
    logic          capture;
    logic [W-1:0]  capture_val;
    logic          capture_valid;
`endif

    int n_checks = 0;
    int n_errors = 0;

    rand_interval_timer #(
        .WIDTH(W),
        .LFSR_W(LW),
        .PRESCALE_W(PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .prescale     (prescale),
        .base         (base),
        .rand_mask    (rand_mask),
        .seed         (seed),
        .seed_load    (seed_load),
`ifdef RIT_CAPTURE_EN
        .capture      (capture),
        .capture_val  (capture_val),
        .capture_valid(capture_valid),
`endif
        .busy         (busy),
        .expire       (expire),
        .count        (count),
        .interval     (interval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    mode;
        logic [PW-1:0] presc;
        logic [W-1:0]  base;
        logic [W-1:0]  mask;
        logic          ld;
        logic [LW-1:0] seed;
        logic [W-1:0]  exp_int;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_expire(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (expire) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int exp_lat;

        // mode, presc, base, mask, ld, seed, expected interval
        tbl[0] = '{2'b00, 16'd0, 8'd3,   8'h00, 1'b0, 16'h0000, 8'd3};
        tbl[1] = '{2'b00, 16'd2, 8'd5,   8'h00, 1'b0, 16'h0000, 8'd5};
        tbl[2] = '{2'b00, 16'd0, 8'd0,   8'h00, 1'b0, 16'h0000, 8'd1};
        tbl[3] = '{2'b10, 16'd0, 8'hF0,  8'hFF, 1'b1, 16'h0001, 8'hF1};
        tbl[4] = '{2'b10, 16'd0, 8'hFF,  8'hFF, 1'b0, 16'h0000, 8'hFF};
        tbl[5] = '{2'b10, 16'd0, 8'h00,  8'h00, 1'b0, 16'h0000, 8'h01};
        tbl[6] = '{2'b10, 16'd1, 8'h01,  8'h0F, 1'b0, 16'h0000, 8'h09};
        tbl[7] = '{2'b10, 16'd0, 8'h02,  8'h03, 1'b0, 16'h0000, 8'h02};

        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        mode = 2'b00;
        prescale = '0;
        base = '0;
        rand_mask = '0;
        seed = '0;
        seed_load = 1'b0;
`ifdef RIT_CAPTURE_EN
        capture = 1'b0;
`endif
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_expire", 32'(expire), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_interval", 32'(interval), 32'd0);
`ifdef RIT_CAPTURE_EN
        check("rst_cap_val", 32'(capture_val), 32'd0);
        check("rst_cap_valid", 32'(capture_valid), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table of one-shot runs, fixed and random.
        for (int i = 0; i < 8; i++) begin
            mode = tbl[i].mode;
            prescale = tbl[i].presc;
            base = tbl[i].base;
            rand_mask = tbl[i].mask;
            if (tbl[i].ld) begin
                seed = tbl[i].seed;
                seed_load = 1'b1;
                @(negedge clk);
                seed_load = 1'b0;
            end
            pulse_start();
            check("busy_load", 32'(busy), 32'd1);
            exp_lat = int'(tbl[i].exp_int) * (int'(tbl[i].presc) + 1) + 1;
            wait_expire(exp_lat + 4, lat);
            check("latency", 32'(lat), 32'(exp_lat));
            check("interval", 32'(interval), 32'(tbl[i].exp_int));
            check("count_end", 32'(count), 32'(tbl[i].exp_int));
            check("busy_done", 32'(busy), 32'd0);
            @(negedge clk);
            check("expire_pulse", 32'(expire), 32'd0);
            check("count_hold", 32'(count), 32'(tbl[i].exp_int));
        end

        // Prescaled periodic: expires at E11, E22, E33.
        mode = 2'b01;
        prescale = 16'd4;
        base = 8'd2;
        rand_mask = 8'h00;
        pulse_start();
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            check("per_expire", 32'(expire), 32'((k % 11) == 0));
        end
        check("per_interval", 32'(interval), 32'd2);
        check("per_busy", 32'(busy), 32'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("per_stop_busy", 32'(busy), 32'd0);

        // Stop on the terminal tick: no expire, count holds at 2.
        mode = 2'b00;
        prescale = 16'd0;
        base = 8'd3;
        pulse_start();
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("abort_expire", 32'(expire), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(count), 32'd2);
        @(negedge clk);
        check("abort_expire2", 32'(expire), 32'd0);
        check("abort_count2", 32'(count), 32'd2);
        check("abort_interval", 32'(interval), 32'd3);

        // Start during RUN is ignored.
        base = 8'd5;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_expire(10, lat);
        check("busy_start_lat", 32'(lat + 3), 32'd6);
        check("busy_start_int", 32'(interval), 32'd5);

        // Zero seed becomes 1: interval = 0x10 + 1.
        mode = 2'b10;
        base = 8'h10;
        rand_mask = 8'hFF;
        seed = '0;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        pulse_start();
        wait_expire(30, lat);
        check("zseed_int", 32'(interval), 32'h11);
        check("zseed_lat", 32'(lat), 32'd18);

        // Seed loaded during LOAD: old value (2) used now, seed next run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed = 16'h0005;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check("ldseed_int", 32'(interval), 32'h12);
        wait_expire(30, lat);
        check("ldseed_lat", 32'(lat + 1), 32'h13);
        pulse_start();
        wait_expire(30, lat);
        check("ldseed_next", 32'(interval), 32'h15);

`ifdef RIT_CAPTURE_EN
        // Capture while count is 37.
        mode = 2'b00;
        base = 8'd100;
        prescale = 16'd0;
        pulse_start();
        repeat (38) @(negedge clk);
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        check("cap_val", 32'(capture_val), 32'd37);
        check("cap_valid", 32'(capture_valid), 32'd1);
        check("cap_busy", 32'(busy), 32'd0);
        check("cap_expire", 32'(expire), 32'd0);
        check("cap_count", 32'(count), 32'd37);
        pulse_start();
        @(negedge clk);
        check("cap_clear", 32'(capture_valid), 32'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        check("cap_idle_ign", 32'(capture_valid), 32'd0);
`endif

        // Asynchronous reset mid-run, then LFSR back at 1.
        mode = 2'b00;
        base = 8'd50;
        pulse_start();
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_interval", 32'(interval), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mode = 2'b10;
        base = 8'h20;
        rand_mask = 8'hFF;
        pulse_start();
        @(negedge clk);
        check("arst_lfsr", 32'(interval), 32'h21);
        wait_expire(40, lat);
        check("arst_lat", 32'(lat + 1), 32'h22);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
